// File: rtl/riscv_pkg.sv
// Shared fetch-side types and constants.
// No logic, no latency.
// No flow control of its own.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] INSTR_NOP        = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] pc_align(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic in-order FIFO with occupancy count and single-cycle flush.
// Latency: a pushed entry is visible at the head the next cycle.
// Backpressure: rd_rdy pops the head; the writer must respect count (no full flag).
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     wr_vld,
    input  logic [WIDTH-1:0]         wr_dat,
    input  logic                     rd_rdy,
    output logic                     rd_vld,
    output logic [WIDTH-1:0]         rd_dat,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             rd_fire;

    assign rd_vld  = (count_q != '0);
    assign rd_dat  = mem_q[rd_ptr_q];
    assign count   = count_q;
    assign rd_fire = rd_vld && rd_rdy;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Flush wins over a simultaneous push or pop.
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_vld) begin
                mem_d[wr_ptr_q] = wr_dat;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (rd_fire) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(wr_vld) - CW'(rd_fire);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(wr_vld && !flush && !rd_fire && (count_q == CW'(DEPTH))));

endmodule

// File: rtl/ifetch_unit.sv
// Fetch stage: owns the PC, issues word fetches, buffers returned words for decode.
// Latency: zero-wait memory gives first id_valid 2 cycles after reset, then 1 instr/cycle.
// Backpressure: requests are credit-limited by buffer space; id_ready stalls the head.
module ifetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int              FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_instr
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d;

    logic [CW-1:0]   fifo_count;
    logic            fifo_vld;
    fetch_entry_t    wr_entry;
    fetch_entry_t    head;
    logic            req_fire;
    logic            rsp_keep;

    // Every in-flight request reserves a buffer slot, so responses can never overflow.
    assign imem_req_valid = !rst && ((fifo_count + outstanding_q) < CW'(FIFO_DEPTH));
    assign imem_req_addr  = rst ? RESET_PC : fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_keep       = imem_rsp_valid && (drop_cnt_q == '0) && !redirect_valid;
    assign wr_entry       = '{pc: rsp_pc_q, instr: imem_rsp_data};

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        drop_cnt_d    = drop_cnt_q;
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_rsp_valid);
        if (req_fire) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
        if (rsp_keep) begin
            rsp_pc_d = rsp_pc_q + 32'd4;
        end
        if (imem_rsp_valid && (drop_cnt_q != '0)) begin
            drop_cnt_d = drop_cnt_q - CW'(1);
        end
        // Whatever is still in flight after this cycle belongs to the old path.
        if (redirect_valid) begin
            fetch_pc_d = pc_align(redirect_pc);
            rsp_pc_d   = pc_align(redirect_pc);
            drop_cnt_d = outstanding_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .flush  (redirect_valid),
        .wr_vld (rsp_keep),
        .wr_dat (wr_entry),
        .rd_rdy (id_ready),
        .rd_vld (fifo_vld),
        .rd_dat (head),
        .count  (fifo_count)
    );

    assign id_valid = fifo_vld;
    assign id_pc    = (fifo_vld && !rst) ? head.pc    : '0;
    assign id_instr = (fifo_vld && !rst) ? head.instr : '0;

    a_rsp_tracked: assert property (@(posedge clk) disable iff (rst)
        imem_rsp_valid |-> (outstanding_q != '0));
    a_credit: assert property (@(posedge clk) disable iff (rst)
        ({1'b0, fifo_count} + {1'b0, outstanding_q}) <= (CW + 1)'(FIFO_DEPTH));
    a_drop_bound: assert property (@(posedge clk) disable iff (rst)
        drop_cnt_q <= outstanding_q);

endmodule

// File: tb/tb_ifetch_unit.sv
// Randomised bench for ifetch_unit: program-order PC stream reference plus in-order memory model.
module tb_ifetch_unit;

    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc    = '0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_pc;
    logic [31:0] id_instr;

    always #5 clk = ~clk;

    ifetch_unit #(
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_pc          (id_pc),
        .id_instr       (id_instr)
    );

    typedef struct {
        int          due;
        logic [31:0] addr;
    } mreq_t;

    mreq_t       memq[$];
    int          cyc = 0;
    int          last_due = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          mem_lat = 1;
    bit          mem_lat_rand = 1'b0;
    logic [31:0] exp_pc = RST_PC;
    logic [31:0] exp_req = RST_PC;
    int          n_acc = 0;
    int          n_del = 0;
    int          n_vld = 0;
    int          rst_cyc = 0;
    bit          chk_idle = 1'b0;
    bit          prev_req_pend = 1'b0;
    logic [31:0] prev_req_addr = '0;
    logic [31:0] first_pc = '0;
    bit          want_first = 1'b0;
    bit          s_id_valid = 1'b0;
    bit          s_req_valid = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle: drive at posedge+1, observe at negedge, model the handshakes.
    task automatic step(input bit r, input bit rdy, input bit mrdy, input bit redir,
                        input logic [31:0] rpc);
        int lat;
        int due;
        cyc++;
        rst = r;
        if (r) begin
            memq.delete();
            last_due = 0;
        end
        if (memq.size() > 0 && memq[0].due == cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(memq[0].addr);
            void'(memq.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        id_ready       = rdy;
        imem_req_ready = mrdy;
        redirect_valid = redir;
        redirect_pc    = redir ? rpc : $urandom;
        @(negedge clk);
        s_id_valid  = id_valid;
        s_req_valid = imem_req_valid;
        if (r) begin
            rst_cyc++;
            check("rst_req_valid", 32'(imem_req_valid), 32'd0);
            check("rst_req_addr", imem_req_addr, RST_PC);
            check("rst_id_pc", id_pc, 32'd0);
            check("rst_id_instr", id_instr, 32'd0);
            if (rst_cyc >= 2) check("rst_id_valid", 32'(id_valid), 32'd0);
            exp_pc        = RST_PC;
            exp_req       = RST_PC;
            chk_idle      = 1'b0;
            prev_req_pend = 1'b0;
        end else begin
            rst_cyc = 0;
            if (chk_idle) check("idle_after_redirect", 32'(id_valid), 32'd0);
            chk_idle = 1'b0;
            if (prev_req_pend) begin
                check("req_hold_valid", 32'(imem_req_valid), 32'd1);
                check("req_hold_addr", imem_req_addr, prev_req_addr);
            end
            if (imem_req_valid && mrdy) begin
                check("req_addr", imem_req_addr, exp_req);
                exp_req = exp_req + 32'd4;
                n_acc++;
                lat = mem_lat_rand ? int'($urandom_range(1, 4)) : mem_lat;
                due = cyc + lat;
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                memq.push_back('{due: due, addr: imem_req_addr});
            end
            prev_req_pend = imem_req_valid && !mrdy && !redir;
            prev_req_addr = imem_req_addr;
            if (id_valid) n_vld++;
            if (id_valid && rdy && !redir) begin
                check("id_pc", id_pc, exp_pc);
                check("id_instr", id_instr, mem_word(exp_pc));
                if (want_first) begin
                    first_pc   = id_pc;
                    want_first = 1'b0;
                end
                exp_pc = exp_pc + 32'd4;
                n_del++;
            end
            if (redir) begin
                exp_pc     = {rpc[31:2], 2'b00};
                exp_req    = {rpc[31:2], 2'b00};
                chk_idle   = 1'b1;
                want_first = 1'b1;
                first_pc   = 32'hDEAD_BEEF;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        for (int k = 0; k < n; k++) step(1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
    endtask

    task automatic run(input int n, input bit rdy);
        for (int k = 0; k < n; k++) step(1'b0, rdy, 1'b1, 1'b0, 32'd0);
    endtask

    initial begin
        @(posedge clk);
        #1;

        // Basic stream, latency and throughput.
        do_reset(3);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
        check("t1_lat_c0", 32'(s_id_valid), 32'd0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
        check("t1_lat_c1", 32'(s_id_valid), 32'd0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
        check("t1_lat_c2", 32'(s_id_valid), 32'd1);
        n_vld = 0;
        run(10, 1'b1);
        check("t1_throughput", n_vld, 32'd10);

        // Decode stalled: credit limit.
        do_reset(2);
        n_acc = 0;
        run(10, 1'b0);
        check("t2_accepts", n_acc, DEPTH);
        check("t2_req_valid_low", 32'(s_req_valid), 32'd0);
        n_del      = 0;
        want_first = 1'b1;
        first_pc   = 32'hDEAD_BEEF;
        run(8, 1'b1);
        check("t2_first_pc", first_pc, RST_PC);
        check("t2_delivered", 32'(n_del >= DEPTH), 32'd1);

        // Slow memory, redirect with requests in flight.
        do_reset(2);
        mem_lat = 3;
        run(2, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0100);
        run(12, 1'b1);
        check("t3_first_pc", first_pc, 32'h0000_0100);
        mem_lat = 1;

        // Redirect coinciding with a pop and a request accept.
        do_reset(2);
        run(6, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_2000);
        check("t4_cond", 32'(s_id_valid && s_req_valid), 32'd1);
        run(6, 1'b1);
        check("t4_first_pc", first_pc, 32'h0000_2000);

        // Misaligned target near the top of the address space: masking and wrap.
        n_del = 0;
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFB);
        run(8, 1'b1);
        check("t5_first_pc", first_pc, 32'hFFFF_FFF8);
        check("t5_wrap_delivered", 32'(n_del >= 3), 32'd1);

        // Reset while buffer holds 3 entries and one request is outstanding.
        do_reset(2);
        run(4, 1'b0);
        check("t6_fifo_busy", 32'(s_id_valid), 32'd1);
        do_reset(2);
        check("t6_req_valid_rst", 32'(s_req_valid), 32'd0);
        want_first = 1'b1;
        first_pc   = 32'hDEAD_BEEF;
        run(4, 1'b1);
        check("t6_refetch_pc", first_pc, RST_PC);

        // Random traffic: variable latency, stalls, redirects, occasional reset.
        mem_lat_rand = 1'b1;
        n_del        = 0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 400) == 0) begin
                do_reset(2);
            end else begin
                step(1'b0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                     $urandom_range(0, 40) == 0, $urandom);
            end
        end
        run(20, 1'b1);
        check("rand_progress", 32'(n_del > 200), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
